// File: rtl/hyperbus_arbiter_if.sv
// Bundles the two requester ports and the HyperBus controller handshake.
// Latency: none (wires only).
// Backpressure: carried by hb_ready/hb_valid; requesters hold req until done.
interface hyperbus_arbiter_if #(
    parameter int ADDR_LENGTH = 32
);
    logic [1:0]               req;
    logic [1:0]               we;
    logic [2*ADDR_LENGTH-1:0] adr;
    logic [15:0]              len;
    logic [31:0]              wdat;
    logic [3:0]               wmask;
    logic [1:0]               ack;
    logic [15:0]              rdat;
    logic [1:0]               done;
    logic                     cfg_done;
    logic [ADDR_LENGTH-1:0]   hb_adr;
    logic [15:0]              hb_dat;
    logic [1:0]               hb_mask;
    logic                     hb_reg_space;
    logic                     hb_wrq;
    logic                     hb_rrq;
    logic [15:0]              hb_dat_o;
    logic                     hb_ready;
    logic                     hb_valid;

    // Environment side: requesters plus the controller's return signals.
    modport master (
        output req, we, adr, len, wdat, wmask, hb_dat_o, hb_ready, hb_valid,
        input  ack, rdat, done, cfg_done, hb_adr, hb_dat, hb_mask,
               hb_reg_space, hb_wrq, hb_rrq
    );

    // Arbiter side.
    modport slave (
        input  req, we, adr, len, wdat, wmask, hb_dat_o, hb_ready, hb_valid,
        output ack, rdat, done, cfg_done, hb_adr, hb_dat, hb_mask,
               hb_reg_space, hb_wrq, hb_rrq
    );
endinterface

// File: rtl/hyperbus_arbiter.sv
// Two-port round-robin arbiter for a HyperBus controller; writes CR0 once after reset.
// Latency: grant 1 cycle after req in IDLE; write ack combinational with hb_ready, read ack 1 cycle after hb_valid.
// Backpressure: words advance only on hb_ready/hb_valid; bursts split at MAXBURST with GAP idle cycles between.
module hyperbus_arbiter #(
    parameter int          ADDR_LENGTH = 32,
    parameter int          MAXBURST    = 64,
    parameter int          GAP         = 4,
    parameter logic [31:0] CFG_ADR     = 32'h0000_0800,
    parameter logic [15:0] CFG_DATA    = 16'h8F1F
) (
    input logic               clk90,
    input logic               rst,
    hyperbus_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAXBURST + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [SW-1:0] SEG_LAST = SW'(MAXBURST - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    typedef enum logic [3:0] {
        ST_CFG  = 4'b0001,
        ST_IDLE = 4'b0010,
        ST_XFER = 4'b0100,
        ST_GAP  = 4'b1000
    } state_t;

    state_t                 state_q, state_d;
    logic                   gnt_q;
    logic                   last_q;
    logic                   we_q;
    logic [7:0]             len_q;
    logic [7:0]             w_q;
    logic [SW-1:0]          s_q;
    logic [GW-1:0]          gap_q;
    logic                   more_q;
    logic [ADDR_LENGTH-1:0] hb_adr_q;
    logic                   hb_wrq_q;
    logic                   hb_rrq_q;
    logic                   hb_reg_q;
    logic                   cfg_done_q;
    logic [1:0]             ack_r_q;
    logic [1:0]             done_q;
    logic [15:0]            rdat_q;

    logic [1:0]             ack_w;
    logic [15:0]            hb_dat_c;
    logic [1:0]             hb_mask_c;

    logic                   sel_port;
    logic                   sel_we;
    logic [ADDR_LENGTH-1:0] sel_adr;
    logic [7:0]             sel_len;
    logic                   cfg_fire;
    logic                   count;
    logic                   word_last;
    logic                   seg_end;

    // Tie goes to the port that was not granted last.
    assign sel_port = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    assign sel_we   = sel_port ? bus.we[1] : bus.we[0];
    assign sel_adr  = sel_port ? bus.adr[2*ADDR_LENGTH-1:ADDR_LENGTH] : bus.adr[ADDR_LENGTH-1:0];
    assign sel_len  = sel_port ? bus.len[15:8] : bus.len[7:0];

    // The CR0 write completes only when the controller sees our request.
    assign cfg_fire  = (state_q == ST_CFG) && hb_wrq_q && bus.hb_ready;
    assign count     = (state_q == ST_XFER) && (we_q ? bus.hb_ready : bus.hb_valid);
    assign word_last = (w_q == (len_q - 8'd1));
    assign seg_end   = count && (word_last || (s_q == SEG_LAST));

    // Next state and the combinational write-side outputs.
    always_comb begin
        state_d   = state_q;
        ack_w     = '0;
        hb_dat_c  = '0;
        hb_mask_c = '0;
        unique case (state_q)
            ST_CFG: begin
                if (hb_wrq_q) hb_dat_c = CFG_DATA;
                if (cfg_fire) state_d = ST_GAP;
            end
            ST_IDLE: begin
                if (|bus.req) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (we_q) begin
                    hb_dat_c     = gnt_q ? bus.wdat[31:16] : bus.wdat[15:0];
                    hb_mask_c    = gnt_q ? bus.wmask[3:2] : bus.wmask[1:0];
                    ack_w[gnt_q] = bus.hb_ready;
                end
                if (seg_end) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = more_q ? ST_XFER : ST_IDLE;
            end
            default: state_d = ST_CFG;
        endcase
    end

    // State register; reset always restarts with the CR0 write.
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) state_q <= ST_CFG;
        else     state_q <= state_d;
    end

    // Grant latch, word/segment counters, controller requests and port strobes.
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            len_q      <= '0;
            w_q        <= '0;
            s_q        <= '0;
            gap_q      <= '0;
            more_q     <= 1'b0;
            hb_adr_q   <= '0;
            hb_wrq_q   <= 1'b0;
            hb_rrq_q   <= 1'b0;
            hb_reg_q   <= 1'b0;
            cfg_done_q <= 1'b0;
            ack_r_q    <= '0;
            done_q     <= '0;
            rdat_q     <= '0;
        end else begin
            ack_r_q <= '0;
            done_q  <= '0;
            unique case (state_q)
                ST_CFG: begin
                    hb_adr_q <= ADDR_LENGTH'(CFG_ADR);
                    hb_reg_q <= 1'b1;
                    hb_wrq_q <= 1'b1;
                    if (cfg_fire) begin
                        hb_wrq_q   <= 1'b0;
                        hb_reg_q   <= 1'b0;
                        cfg_done_q <= 1'b1;
                        gap_q      <= GAP_LOAD;
                        more_q     <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_q    <= sel_port;
                        last_q   <= sel_port;
                        we_q     <= sel_we;
                        hb_adr_q <= sel_adr;
                        len_q    <= (sel_len == 8'd0) ? 8'd1 : sel_len;
                        w_q      <= '0;
                        s_q      <= '0;
                        hb_wrq_q <= sel_we;
                        hb_rrq_q <= ~sel_we;
                        hb_reg_q <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (count) begin
                        w_q <= w_q + 8'd1;
                        s_q <= s_q + SW'(1);
                        if (!we_q) begin
                            ack_r_q[gnt_q] <= 1'b1;
                            rdat_q         <= bus.hb_dat_o;
                        end
                    end
                    if (seg_end) begin
                        hb_wrq_q <= 1'b0;
                        hb_rrq_q <= 1'b0;
                        gap_q    <= GAP_LOAD;
                        more_q   <= ~word_last;
                        if (word_last) done_q[gnt_q] <= 1'b1;
                        else           hb_adr_q <= hb_adr_q + ADDR_LENGTH'(MAXBURST);
                    end
                end
                ST_GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GW'(1);
                    end else if (more_q) begin
                        s_q      <= '0;
                        hb_wrq_q <= we_q;
                        hb_rrq_q <= ~we_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ack          = ack_r_q | ack_w;
    assign bus.rdat         = rdat_q;
    assign bus.done         = done_q;
    assign bus.cfg_done     = cfg_done_q;
    assign bus.hb_adr       = hb_adr_q;
    assign bus.hb_dat       = hb_dat_c;
    assign bus.hb_mask      = hb_mask_c;
    assign bus.hb_reg_space = hb_reg_q;
    assign bus.hb_wrq       = hb_wrq_q;
    assign bus.hb_rrq       = hb_rrq_q;
endmodule

// File: doc/hyperbus_arbiter.md
HYPERBUS_ARBITER -- requirements
Module: hyperbus_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_LENGTH, default 32, word address width.
- MAXBURST, default 64, maximum words per chip-select assertion.
- GAP, default 4, idle cycles between controller transactions.
- CFG_ADR, default 32'h0000_0800, CR0 register address.
- CFG_DATA, default 16'h8F1F, CR0 value written after reset.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk90, in, 1: clock, same frequency as controller clock, 90 degrees shifted; all logic on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- req, in, 2: per-port request; held until done.
- we, in, 2: per-port write (1) or read (0).
- adr, in, 2*ADDR_LENGTH: per-port start word address; port i at [i*ADDR_LENGTH +: ADDR_LENGTH].
- len, in, 16: per-port burst length in words, 8 bits each; 0 is treated as 1.
- wdat, in, 32: per-port write data, 16 bits each.
- wmask, in, 4: per-port byte mask, 2 bits each.
- ack, out, 2: per-port word strobe (write word consumed, or read word valid).
- rdat, out, 16: read data, shared by both ports.
- done, out, 2: one-cycle pulse when the port's burst completes.
- cfg_done, out, 1: configuration write finished.
- hb_adr, out, ADDR_LENGTH: address to the controller.
- hb_dat, out, 16: write data to the controller.
- hb_mask, out, 2: write mask to the controller.
- hb_reg_space, out, 1: register-space select to the controller.
- hb_wrq, out, 1: write request to the controller.
- hb_rrq, out, 1: read request to the controller.
- hb_dat_o, in, 16: read data from the controller.
- hb_ready, in, 1: controller consumes hb_dat this cycle.
- hb_valid, in, 1: hb_dat_o valid this cycle.

Function
REQ-003 States SHALL be CFG, IDLE, XFER, GAP; the state register SHALL be one-hot.

REQ-004 CFG behaviour:
- Entered from reset.
- SHALL drive hb_wrq=1, hb_reg_space=1, hb_adr=CFG_ADR, hb_dat=CFG_DATA, hb_mask=0.
- On the first cycle with hb_ready=1: hb_wrq drops the next cycle, cfg_done sets, and the state moves to GAP.

REQ-005 cfg_done SHALL remain 1 until reset; no port SHALL be granted before cfg_done=1.

REQ-006 In IDLE, grant SHALL be round-robin:
- A single requesting port is granted.
- When both ports request in the same cycle, the port not granted last is granted.
- The last-granted register resets to port 1, so port 0 wins the first tie.

REQ-007 Grant SHALL latch at grant time:
- port index, we, adr, and effective length L = max(len,1).
- word counter W=0, segment counter S=0.
- Then enter XFER with hb_wrq=we or hb_rrq=~we, and hb_reg_space=0.

REQ-008 In XFER write:
- hb_dat and hb_mask SHALL combinationally select the granted port's wdat and wmask.
- ack[g] SHALL equal hb_ready combinationally.
- Each hb_ready cycle SHALL increment W and S.

REQ-009 In XFER read:
- On each hb_valid, ack[g] SHALL pulse one cycle later with rdat=hb_dat_o registered.
- W and S increment on the same edge.

REQ-010 The segment SHALL end when W+1==L or S+1==MAXBURST on a counting cycle:
- hb_wrq and hb_rrq SHALL be 0 from the next cycle.
- The state moves to GAP with a counter loaded to GAP-1.

REQ-011 When the segment ends with W<L, the latched address SHALL advance by MAXBURST (ADDR_LENGTH-bit modulo). After GAP, XFER SHALL re-enter for the same port with S=0 and no re-arbitration.

REQ-012 When W reaches L:
- done[g] SHALL pulse one cycle, coincident with the GAP entry.
- GAP then returns to IDLE.

REQ-013 hb_adr SHALL be stable while hb_wrq or hb_rrq is 1; the two requests SHALL never be 1 together.

REQ-014 Only the granted port is acked. Changes to req, adr, len or we on the granted port mid-burst SHALL be ignored until done.

REQ-015 A hb_valid or hb_ready outside XFER (or CFG for hb_ready) SHALL be ignored, with no ack and no counter change.

REQ-016 Address wrap at 2^ADDR_LENGTH SHALL wrap silently. L=255 with MAXBURST=64 SHALL produce segments of 64, 64, 64, 63.

Reset
REQ-017 On rst=1, asynchronously:
- state=CFG.
- hb_wrq=0, hb_rrq=0, hb_reg_space=0, hb_adr=0.
- ack=0, done=0, cfg_done=0, rdat=0.
- counters 0, last-granted=1.
- After release, hb_wrq=1 on the first clk90 edge.

REQ-018 Reset mid-burst SHALL abort the transfer with no done pulse and SHALL rerun CFG after release.

Verification
REQ-019 Reset release, hb_ready pulsed at cycle 10 -> CFG write seen:
- hb_wrq high cycles 1-10 with hb_reg_space=1, hb_adr=0x800, hb_dat=0x8F1F.
- cfg_done=1 from cycle 11.
- No grant before then.

REQ-020 Port 0 write, adr=0x100, len=4, hb_ready high 4 cycles:
- ack[0] for 4 cycles, hb_dat tracks wdat[15:0].
- hb_wrq drops after the 4th word.
- done[0] pulses once.

REQ-021 Both ports read in the same cycle after reset, len=2, hb_valid pulses:
- Port 0 served first, then after GAP port 1.
- A repeat tie is served port 0 next (alternation).
- rdat matches hb_dat_o one cycle later.

REQ-022 Port 1 read, adr=0x3FFF_FFF0, len=130 -> three segments:
- 64 words at 0x3FFF_FFF0, 64 at 0x4000_0030, 2 at 0x4000_0070.
- GAP idle between segments.
- A single done[1] pulse.

REQ-023 len=0 write -> exactly one word acked, then done.

REQ-024 rst asserted during word 3 of a len=8 read:
- All outputs zero immediately.
- No done pulse.
- CFG reruns after release.
